// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Multiplexed seven-segment scan controller. A prescaler divides clk into
//   digit slots of REFRESH_DIV cycles. Each slot begins with BLANK_CYCLES of
//   dead time. Display data is double-buffered: loads land in a pending set,
//   and the pending set moves into the active set only at the frame wrap, so
//   a frame is never shown half old and half new.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   data        4*NUM_DIGITS nibbles, nibble i = digit i (digit 0 is the LSD)
//   dp_in       per-digit decimal-point request
//   load        capture data/dp_in into the pending set
//   digit_en    per-digit enable (0 forces that digit dark)
//   lzb         leading-zero blanking enable
//   hex_out     registered active nibble of the current slot
//   dp_out      registered decimal point, active high
//   an          registered active-low one-hot anode enables
//   digit_idx   current slot index
//   frame_done  one-cycle pulse after the frame-wrap edge
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lzb,
  output logic [3:0]                    hex_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(REFRESH_DIV);

  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              hex_q, hex_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap;
  logic                    visible;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   supp;

  assign tick = (pcnt_q == PCNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // A digit is suppressed when it and every digit above it hold zero.
  // Walking down from the top keeps a running "all zero so far" flag.
  // Digit 0 is never suppressed so a zero value still shows one '0'.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (act_data_q[4*i +: 4] == 4'h0);
      supp[i]  = lzb & zero_run;
    end
  end

  assign visible = (pcnt_q >= PCNT_W'(BLANK_CYCLES)) && digit_en[idx_q] && !supp[idx_q];

  always_comb begin
    pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // The active set is swapped before pending is overwritten, so a load
    // coinciding with the wrap shows the older pending value this frame and
    // keeps the new one pending for the next frame.
    if (wrap && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    // Outputs are registered from this cycle's slot state, giving one cycle
    // of latency. hex_out follows the active nibble even while blanked.
    an_d         = visible ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    dp_d         = visible & act_dp_q[idx_q];
    hex_d        = act_data_q[{idx_q, 2'b00} +: 4];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      an_q         <= '1;
      hex_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign hex_out    = hex_q;
  assign dp_out     = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic          load;
  logic [3:0]    digit_en;
  logic          lzb;
  logic [3:0]    hex_out;
  logic          dp_out;
  logic [3:0]    an;
  logic [1:0]    digit_idx;
  logic          frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .dp_in     (dp_in),
    .load      (load),
    .digit_en  (digit_en),
    .lzb       (lzb),
    .hex_out   (hex_out),
    .dp_out    (dp_out),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: time since reset is a plain cycle count k; slot and
  // phase follow from division, frame wrap from k mod (N*R).
  int          m_k;
  int          last_k;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pend_dp, m_act_dp;
  logic        m_pv;

  task automatic model_edge();
    int pc, slot;
    bit wrap, supp, vis;
    logic [3:0] oh, e_an, e_hex;
    logic e_dp;
    logic [1:0] e_idx;
    if (reset) begin
      m_k = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0; m_pv = 1'b0;
      last_k = -1;
      exp_q.push_back({4'hF, 4'h0, 1'b0, 1'b0, 2'd0});
    end else begin
      pc    = m_k % R;
      slot  = (m_k / R) % N;
      wrap  = (m_k % (N * R)) == (N * R - 1);
      e_hex = m_act[4*slot +: 4];
      supp  = lzb && (slot > 0) && ((m_act >> (4 * slot)) == 16'h0);
      vis   = (pc >= B) && digit_en[slot] && !supp;
      oh    = 4'b0001 << slot;
      e_an  = vis ? ~oh : 4'hF;
      e_dp  = vis && m_act_dp[slot];
      if (wrap && m_pv) begin
        m_act = m_pend; m_act_dp = m_pend_dp;
      end
      if (load) begin
        m_pend = data; m_pend_dp = dp_in; m_pv = 1'b1;
      end else if (wrap) begin
        m_pv = 1'b0;
      end
      last_k = m_k;
      m_k++;
      e_idx = 2'((m_k / R) % N);
      exp_q.push_back({e_an, e_hex, e_dp, wrap, e_idx});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [W-1:0] got, want;
    model_edge();
    @(posedge clk);
    #1;
    got  = {an, hex_out, dp_out, frame_done, digit_idx};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL scoreboard k=%0d got an=%h hex=%h dp=%b fd=%b idx=%0d want an=%h hex=%h dp=%b fd=%b idx=%0d",
               last_k, got[11:8], got[7:4], got[3], got[2], got[1:0],
               want[11:8], want[7:4], want[3], want[2], want[1:0]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s k=%0d got=%h want=%h", name, last_k, got, want);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; load = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  // x_an / x_hex hold the per-slot expectation at [4*slot +: 4] for the
  // visible part of each slot in the frame after the load takes effect.
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [15:0] x_an;
    logic [15:0] x_hex;
    logic [3:0]  x_dp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int slot, pc, pulses;
    reset = 1'b0; data = '0; dp_in = '0; load = 1'b0; digit_en = 4'hF; lzb = 1'b0;

    vecs[0] = '{d:16'h1234, dp:4'b0000, en:4'hF,    lz:1'b0, x_an:16'h7BDE, x_hex:16'h1234, x_dp:4'b0000};
    vecs[1] = '{d:16'h0050, dp:4'b0000, en:4'hF,    lz:1'b1, x_an:16'hFFDE, x_hex:16'h0050, x_dp:4'b0000};
    vecs[2] = '{d:16'h0000, dp:4'b1111, en:4'hF,    lz:1'b1, x_an:16'hFFFE, x_hex:16'h0000, x_dp:4'b0001};
    vecs[3] = '{d:16'h1234, dp:4'b0001, en:4'b0101, lz:1'b0, x_an:16'hFBFE, x_hex:16'h1234, x_dp:4'b0001};
    vecs[4] = '{d:16'h8000, dp:4'b1010, en:4'hF,    lz:1'b1, x_an:16'h7BDE, x_hex:16'h8000, x_dp:4'b1010};

    for (int v = 0; v < 5; v++) begin
      apply_reset();
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_hex", 32'(hex_out), 32'h0);
      digit_en = vecs[v].en; lzb = vecs[v].lz;
      data = vecs[v].d; dp_in = vecs[v].dp; load = 1'b1;
      step();
      load = 1'b0; data = 16'hFFFF; dp_in = 4'hF;
      for (int c = 0; c < 63; c++) begin
        step();
        if (last_k < 32) begin
          chk("first_frame_hex", 32'(hex_out), 32'h0);
        end else begin
          slot = (last_k - 32) / R;
          pc   = last_k % R;
          chk("tbl_an", 32'(an), (pc >= B) ? 32'(vecs[v].x_an[4*slot +: 4]) : 32'hF);
          chk("tbl_hex", 32'(hex_out), 32'(vecs[v].x_hex[4*slot +: 4]));
          chk("tbl_dp", 32'(dp_out), (pc >= B) ? 32'(vecs[v].x_dp[slot]) : 32'h0);
        end
      end
    end

    // frame_done period and width
    digit_en = 4'hF; lzb = 1'b0;
    apply_reset();
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (frame_done) begin
        pulses++;
        chk("fd_phase", 32'(last_k % 32), 32'd31);
      end
    end
    chk("fd_count", 32'(pulses), 32'd3);

    // load coinciding with the frame-wrap tick
    apply_reset();
    data = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    repeat (30) step();
    data = 16'hAAAA; load = 1'b1;
    step();
    chk("wrap_load_k", 32'(last_k), 32'd31);
    load = 1'b0;
    for (int c = 0; c < 64; c++) begin
      step();
      chk("wrap_load_hex", 32'(hex_out), (last_k < 64) ? 32'h5 : 32'hA);
    end

    // reset in the middle of slot 2 with pending data outstanding
    apply_reset();
    data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    repeat (49) step();
    data = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    step();
    reset = 1'b1; load = 1'b1; data = 16'hFFFF;
    step();
    chk("mid_reset_an", 32'(an), 32'hF);
    chk("mid_reset_hex", 32'(hex_out), 32'h0);
    chk("mid_reset_dp", 32'(dp_out), 32'h0);
    chk("mid_reset_fd", 32'(frame_done), 32'h0);
    chk("mid_reset_idx", 32'(digit_idx), 32'h0);
    reset = 1'b0; load = 1'b0;
    step();
    chk("resume_idx", 32'(digit_idx), 32'h0);
    chk("resume_an", 32'(an), 32'hF);
    for (int c = 0; c < 40; c++) begin
      step();
      chk("pending_lost_hex", 32'(hex_out), 32'h0);
    end

    // randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 7) == 0);
      data  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) lzb = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, 2..8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, at least 4.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 4: dead-time cycles at the start of each slot, less than REFRESH_DIV.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port data, input, 4*NUM_DIGITS bits: nibble i is digit i; digit 0 is least significant.
REQ-007 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal-point request per digit.
REQ-008 The block SHALL have port load, input, 1 bit: when high, data and dp_in SHALL be captured into the pending register.
REQ-009 The block SHALL have port digit_en, input, NUM_DIGITS bits: per-digit enable; 0 forces that digit blank.
REQ-010 The block SHALL have port lzb, input, 1 bit: leading-zero blanking enable.
REQ-011 The block SHALL have port hex_out, output, 4 bits: nibble fed to the downstream hex-to-7-segment decoder.
REQ-012 The block SHALL have port dp_out, output, 1 bit: active-high decimal point for the lit digit.
REQ-013 The block SHALL have port an, output, NUM_DIGITS bits: active-low one-hot anode enables.
REQ-014 The block SHALL have port digit_idx, output, clog2(NUM_DIGITS) bits: current slot index.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame wrap.

Function
REQ-016 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick = (pcnt == REFRESH_DIV-1).
REQ-017 On tick, digit_idx SHALL increment; from NUM_DIGITS-1 it SHALL wrap to 0 (this is the frame wrap).
REQ-018 frame_done SHALL be 1 for exactly the one cycle after the frame-wrap tick edge, giving period NUM_DIGITS*REFRESH_DIV cycles.
REQ-019 Register sets: pending (data, dp) with pending_valid, and active (data, dp); the display SHALL use only the active set.
REQ-020 load=1 SHALL write pending and set pending_valid on the next edge.
REQ-021 On the frame-wrap tick, if pending_valid, active SHALL take pending and pending_valid SHALL clear, so no frame tears.
REQ-022 If load and the frame-wrap tick coincide, active SHALL take the old pending value, pending SHALL take the new data, and pending_valid SHALL stay 1.
REQ-023 Suppression: digit i>0 SHALL be suppressed when lzb=1 and active nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-024 Visible condition = pcnt >= BLANK_CYCLES and digit_en[digit_idx] and not suppressed.
REQ-025 an, hex_out and dp_out SHALL be registered, each reflecting the pcnt and digit_idx of the previous cycle (1-cycle latency).
REQ-026 When visible, an SHALL be low only at bit digit_idx, and dp_out SHALL equal active dp[digit_idx].
REQ-027 When not visible, an SHALL be all ones and dp_out SHALL be 0.
REQ-028 hex_out SHALL always equal active nibble[digit_idx], even when blanked.

Reset
REQ-029 With reset=1 at an edge: pcnt=0, digit_idx=0, pending=0, active=0, pending_valid=0, an all ones, hex_out=0, dp_out=0, frame_done=0.
REQ-030 Reset SHALL take priority over load and tick.
REQ-031 Reset mid-frame SHALL discard any pending data and restart at slot 0 with blanking.

Verification
Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 for all scenarios.
REQ-032 Reset, then load data=16'h1234, digit_en=4'hF, lzb=0 -> first frame shows 0s; next frame gives hex_out 4,3,2,1; an 1110/1101/1011/0111, each all-ones for 2 cycles then low for 6.
REQ-033 Run continuously -> frame_done pulses every 32 cycles, width 1 cycle.
REQ-034 lzb=1 with data=16'h0050 -> digits 3 and 2 keep an=4'hF in their slots; digit 1 shows 5, digit 0 shows 0; data=0 -> only digit 0 lit.
REQ-035 Load 16'hAAAA in the frame-wrap cycle while pending=16'h5555 -> that frame shows 5s, next frame shows As.
REQ-036 digit_en=4'b0101, dp_in=4'b0001 -> an never low at bits 1 and 3; dp_out=1 only in slot 0's visible cycles.
REQ-037 Assert reset mid-slot 2 -> next cycle matches REQ-029; pending data lost; scan resumes from digit 0.
